yutorina_exp_unit: RTL and testbench
====================================

# yutorina_exp_unit

Exception source for the Yutorina pipeline. Sits at the MEM stage boundary. Merges each retiring instruction's propagated exception code with the external interrupt request and selects one event. Drives the exception code and its active-low strobe into the pipeline controller, waits for the controller's flush, then redirects fetch to the vector. Also owns EPC, CAUSE and the interrupt-enable CSRs, and performs ERET.

## Interface
- Parameters:
- ADDR_W, 30, word-address width of PC/EPC/vector
- EXP_W, 3, exception code width; code 0 = EXP_NONE
- VECTOR, 30'h0000_0004, handler word address
- EXP_IRQ, 3'd6, code reported for an external interrupt
- Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall (i_busy | d_busy)
- flush  in  1  registered flush from controller
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  ADDR_W  its word PC
- mem_exp  in  EXP_W  exception code carried down the pipe
- mem_eret  in  1  instruction is ERET
- irq_req  in  1  level external interrupt
- csr_we  in  1  CSR write strobe
- csr_addr  in  2  0=STATUS(bit0 IE, bit1 saved IE), 1=CAUSE, 2=EPC
- csr_wdata  in  32  write data
- csr_rdata  out  32  combinational read, zero-extended; addr 3 reads 0
- exp_code  out  EXP_W  code to controller
- exp_en_  out  1  active-low qualifier for exp_code
- new_pc_en  out  1  fetch redirect strobe
- new_pc  out  ADDR_W  redirect target

## Operation
- States: IDLE, REPORT, WAIT_FLUSH, REDIRECT.
- Reset values: state=IDLE, exp_code=0, exp_en_=1, new_pc_en=0, new_pc=0, EPC=0, CAUSE=0, IE=0, saved IE=0.
- IDLE: the event is sampled only when mem_valid=1 and stall=0.
  - Priority 1: mem_exp≠0. EPC←mem_pc, CAUSE←mem_exp.
  - Priority 2: irq_req & IE. EPC←mem_pc, CAUSE←EXP_IRQ.
  - On entry from either priority: saved IE←IE, IE←0, exp_code←CAUSE value, exp_en_←0, go to REPORT.
- ERET in IDLE (mem_valid, !stall, mem_eret, no exception and no interrupt taken):
  - IE←saved IE.
  - new_pc←EPC, new_pc_en←1, go to REDIRECT.
  - No report is made to the controller.
- REPORT: lasts exactly one cycle regardless of stall. Then exp_en_←1, exp_code←0, go to WAIT_FLUSH.
- WAIT_FLUSH: stall is ignored. On flush=1: new_pc←VECTOR, new_pc_en←1, go to REDIRECT.
- REDIRECT: new_pc_en held while stall=1. First cycle with stall=0: new_pc_en←0, go to IDLE.
- Outside IDLE, mem_exp, irq_req and mem_eret are ignored.
- CSR writes:
  - Applied on any cycle with csr_we=1.
  - An entry or ERET update in the same cycle overrides the CSR write for any register both touch.
  - Only CAUSE[EXP_W-1:0] and EPC[ADDR_W+1:2] (word address in byte-address form) are writable.
- csr_rdata EPC field returns {EPC,2'b00}.

## Timing
- Exception sampled at edge t → exp_en_=0 with code valid during cycle t..t+1 (one cycle only).
- Controller flush is expected at edge t+2. new_pc_en rises at the edge after flush is seen high, i.e. t+3 nominally.
- ERET sampled at edge t → new_pc_en=1, new_pc=EPC from t; deasserted at t+1 if no stall.
- Sync reset in any state → all outputs at reset values after the next edge. No redirect is issued.
- Back-to-back exceptions: the second is ignored until the FSM is back in IDLE. The pipeline flush squashes it.

## Test plan
- Reset, then mem_valid=1, mem_exp=3, mem_pc=0x100, stall=0 → next cycle exp_code=3, exp_en_=0 for one cycle. Drive flush=1 two cycles later → new_pc_en=1 with new_pc=0x4 for one cycle; CSR EPC reads 0x400, CAUSE reads 3, IE reads 0.
- IE=1 via csr write 0x1, irq_req=1, mem_valid=1, mem_pc=0x20 → exp_code=6. After the sequence: EPC=0x20, STATUS=0x2. Then ERET → new_pc=0x20, STATUS bit0=1.
- mem_exp=1 and irq_req=1 with IE=1 in the same cycle → exp_code=1 only; irq still pending after return.
- stall=1 with mem_exp=2 held for 3 cycles → no report. When stall drops, report occurs one cycle later. Stall during REDIRECT → new_pc_en stays 1 until stall clears.
- Assert rst while in WAIT_FLUSH, then give flush=1 → no new_pc_en; all outputs and CSRs at reset values.
- csr_we writing CAUSE=5 in the same cycle as an exception with code 2 is sampled → CAUSE reads 2.

Source files
------------

// File: rtl/yutorina_exp_unit.sv
// yutorina_exp_unit: MEM-stage exception source for the Yutorina pipeline.
// Picks one event per retiring instruction (propagated exception first, then
// enabled external interrupt), reports it to the controller, waits for the
// flush and redirects fetch to the handler. Owns STATUS/CAUSE/EPC and ERET.
module yutorina_exp_unit #(
    parameter int unsigned        ADDR_W  = 30,
    parameter int unsigned        EXP_W   = 3,
    parameter logic [ADDR_W-1:0]  VECTOR  = ADDR_W'(4),
    parameter logic [EXP_W-1:0]   EXP_IRQ = EXP_W'(6)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [EXP_W-1:0]  mem_exp,
    input  logic              mem_eret,
    input  logic              irq_req,
    input  logic              csr_we,
    input  logic [1:0]        csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output logic [EXP_W-1:0]  exp_code,
    output logic              exp_en_,
    output logic              new_pc_en,
    output logic [ADDR_W-1:0] new_pc
);

    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  CSR_STATUS = 2'd0;
    localparam logic [1:0]  CSR_CAUSE  = 2'd1;
    localparam logic [1:0]  CSR_EPC    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REPORT     = 2'd1,
        ST_WAIT_FLUSH = 2'd2,
        ST_REDIRECT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   exp_code_q, exp_code_d;
    logic               exp_en_n_q, exp_en_n_d;
    logic               new_pc_en_q, new_pc_en_d;
    logic [ADDR_W-1:0]  new_pc_q, new_pc_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic [EXP_W-1:0]   cause_q, cause_d;
    logic               ie_q, ie_d;
    logic               sie_q, sie_d;

    logic               sample;
    logic               take_exp;
    logic               take_irq;
    logic               take_eret;

    // An instruction only counts when it really retires this cycle.
    assign sample    = mem_valid && !stall;
    assign take_exp  = sample && (mem_exp != '0);
    assign take_irq  = sample && irq_req && ie_q;
    assign take_eret = sample && mem_eret;

    // Next-state, CSR update and registered-output computation.
    always_comb begin
        state_d     = state_q;
        exp_code_d  = exp_code_q;
        exp_en_n_d  = exp_en_n_q;
        new_pc_en_d = new_pc_en_q;
        new_pc_d    = new_pc_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        ie_d        = ie_q;
        sie_d       = sie_q;

        // Software CSR writes land first so that hardware updates below win.
        if (csr_we) begin
            case (csr_addr)
                CSR_STATUS: begin
                    ie_d  = csr_wdata[0];
                    sie_d = csr_wdata[1];
                end
                CSR_CAUSE: cause_d = csr_wdata[EXP_W-1:0];
                CSR_EPC:   epc_d   = csr_wdata[ADDR_W+1:2];
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (take_exp || take_irq) begin
                    epc_d      = mem_pc;
                    cause_d    = take_exp ? mem_exp : EXP_IRQ;
                    exp_code_d = take_exp ? mem_exp : EXP_IRQ;
                    sie_d      = ie_q;
                    ie_d       = 1'b0;
                    exp_en_n_d = 1'b0;
                    state_d    = ST_REPORT;
                end else if (take_eret) begin
                    ie_d        = sie_q;
                    new_pc_d    = epc_q;
                    new_pc_en_d = 1'b1;
                    state_d     = ST_REDIRECT;
                end
            end
            ST_REPORT: begin
                // Strobe is exactly one cycle wide, stall or not.
                exp_en_n_d = 1'b1;
                exp_code_d = '0;
                state_d    = ST_WAIT_FLUSH;
            end
            ST_WAIT_FLUSH: begin
                if (flush) begin
                    new_pc_d    = VECTOR;
                    new_pc_en_d = 1'b1;
                    state_d     = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // Hold the redirect until fetch can accept it.
                if (!stall) begin
                    new_pc_en_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and CSR registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            exp_code_q  <= '0;
            exp_en_n_q  <= 1'b1;
            new_pc_en_q <= 1'b0;
            new_pc_q    <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            ie_q        <= 1'b0;
            sie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_code_q  <= exp_code_d;
            exp_en_n_q  <= exp_en_n_d;
            new_pc_en_q <= new_pc_en_d;
            new_pc_q    <= new_pc_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            ie_q        <= ie_d;
            sie_q       <= sie_d;
        end
    end

    // Combinational CSR read; EPC is presented as a byte address.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_STATUS: csr_rdata = DATA_W'({sie_q, ie_q});
            CSR_CAUSE:  csr_rdata = DATA_W'(cause_q);
            CSR_EPC:    csr_rdata = DATA_W'({epc_q, 2'b00});
            default:    csr_rdata = '0;
        endcase
    end

    assign exp_code  = exp_code_q;
    assign exp_en_   = exp_en_n_q;
    assign new_pc_en = new_pc_en_q;
    assign new_pc    = new_pc_q;

endmodule

// File: tb/tb_yutorina_exp_unit.sv
// Bench for yutorina_exp_unit: expected controller reports and fetch redirects
// are queued as stimulus is driven and matched cycle by cycle by a monitor.
module tb_yutorina_exp_unit;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned EXP_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_pc;
    logic [EXP_W-1:0]  mem_exp;
    logic              mem_eret;
    logic              irq_req;
    logic              csr_we;
    logic [1:0]        csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic [EXP_W-1:0]  exp_code;
    logic              exp_en_;
    logic              new_pc_en;
    logic [ADDR_W-1:0] new_pc;

    int checks   = 0;
    int failures = 0;

    // Event words: {2'b01, code} for a report, {2'b10, pc} for a redirect.
    logic [31:0] sb[$];

    yutorina_exp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .mem_valid (mem_valid),
        .mem_pc    (mem_pc),
        .mem_exp   (mem_exp),
        .mem_eret  (mem_eret),
        .irq_req   (irq_req),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .exp_code  (exp_code),
        .exp_en_   (exp_en_),
        .new_pc_en (new_pc_en),
        .new_pc    (new_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    function automatic logic [31:0] rep_ev(input logic [EXP_W-1:0] c);
        return {2'b01, 30'(c)};
    endfunction

    function automatic logic [31:0] red_ev(input logic [ADDR_W-1:0] pc);
        return {2'b10, pc};
    endfunction

    // Every cycle with an active strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (exp_en_ === 1'b0) begin
            if (sb.size() == 0) check("spurious_report", rep_ev(exp_code), 32'hFFFF_FFFF);
            else check("report", rep_ev(exp_code), sb.pop_front());
        end
        if (new_pc_en === 1'b1) begin
            if (sb.size() == 0) check("spurious_redirect", red_ev(new_pc), 32'hFFFF_FFFF);
            else check("redirect", red_ev(new_pc), sb.pop_front());
        end
    end

    // Exception handshake from IDLE through the vector redirect.
    task automatic take_exception(input logic [ADDR_W-1:0] pc, input logic [EXP_W-1:0] code,
                                  input logic [EXP_W-1:0] exp_rep, input logic irq);
        mem_valid = 1'b1; mem_pc = pc; mem_exp = code; irq_req = irq;
        sb.push_back(rep_ev(exp_rep));
        tick();
        mem_valid = 1'b0; mem_exp = '0;
        tick();
        flush = 1'b1;
        sb.push_back(red_ev(ADDR_W'(4)));
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic do_eret(input logic [ADDR_W-1:0] epc);
        mem_valid = 1'b1; mem_eret = 1'b1; mem_pc = ADDR_W'(12'h200);
        sb.push_back(red_ev(epc));
        tick();
        mem_valid = 1'b0; mem_eret = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_pc = '0;
        mem_exp = '0; mem_eret = 1'b0; irq_req = 1'b0; csr_we = 1'b0;
        csr_addr = '0; csr_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values.
        check("rst_exp_code", 32'(exp_code), 32'd0);
        check("rst_exp_en_", 32'(exp_en_), 32'd1);
        check("rst_new_pc_en", 32'(new_pc_en), 32'd0);
        check("rst_new_pc", 32'(new_pc), 32'd0);
        csr_chk("rst_status", 2'd0, 32'd0);
        csr_chk("rst_cause", 2'd1, 32'd0);
        csr_chk("rst_epc", 2'd2, 32'd0);
        tick();

        // Plain exception with code 3 at 0x100.
        take_exception(ADDR_W'(12'h100), 3'd3, 3'd3, 1'b0);
        csr_chk("t1_epc", 2'd2, 32'h400);
        csr_chk("t1_cause", 2'd1, 32'd3);
        csr_chk("t1_status", 2'd0, 32'd0);
        tick();

        // Enabled interrupt, then ERET back to the interrupted PC.
        csr_we = 1'b1; csr_addr = 2'd0; csr_wdata = 32'h1;
        tick();
        csr_we = 1'b0;
        csr_chk("t2_ie_set", 2'd0, 32'h1);
        take_exception(ADDR_W'(8'h20), 3'd0, 3'd6, 1'b1);
        irq_req = 1'b0;
        csr_chk("t2_epc", 2'd2, 32'h80);
        csr_chk("t2_status", 2'd0, 32'h2);
        csr_chk("t2_cause", 2'd1, 32'd6);
        tick();
        do_eret(ADDR_W'(8'h20));
        csr_chk("t2_eret_status", 2'd0, 32'h3);
        tick();

        // Exception beats interrupt; interrupt still pending after return.
        take_exception(ADDR_W'(8'h30), 3'd1, 3'd1, 1'b1);
        csr_chk("t3_cause", 2'd1, 32'd1);
        do_eret(ADDR_W'(8'h30));
        take_exception(ADDR_W'(8'h40), 3'd0, 3'd6, 1'b1);
        irq_req = 1'b0;
        csr_chk("t3_irq_cause", 2'd1, 32'd6);
        csr_chk("t3_irq_epc", 2'd2, 32'h100);
        tick();

        // Stalled exception is not sampled; stall ignored in REPORT/WAIT_FLUSH,
        // honoured in REDIRECT.
        stall = 1'b1; mem_valid = 1'b1; mem_exp = 3'd2; mem_pc = ADDR_W'(8'h50);
        repeat (3) tick();
        stall = 1'b0;
        sb.push_back(rep_ev(3'd2));
        tick();
        mem_valid = 1'b0; mem_exp = '0; stall = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        sb.push_back(red_ev(ADDR_W'(4)));
        tick();
        flush = 1'b0;
        sb.push_back(red_ev(ADDR_W'(4)));
        sb.push_back(red_ev(ADDR_W'(4)));
        tick();
        tick();
        stall = 1'b0;
        tick();
        check("t4_released", 32'(new_pc_en), 32'd0);
        csr_chk("t4_epc", 2'd2, 32'h140);

        // Reset while waiting for flush: no redirect, everything cleared.
        mem_valid = 1'b1; mem_exp = 3'd5; mem_pc = ADDR_W'(8'h60);
        sb.push_back(rep_ev(3'd5));
        tick();
        mem_valid = 1'b0; mem_exp = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t5_exp_en_", 32'(exp_en_), 32'd1);
        check("t5_new_pc_en", 32'(new_pc_en), 32'd0);
        check("t5_new_pc", 32'(new_pc), 32'd0);
        csr_chk("t5_status", 2'd0, 32'd0);
        csr_chk("t5_cause", 2'd1, 32'd0);
        csr_chk("t5_epc", 2'd2, 32'd0);
        tick();

        // Hardware entry overrides a simultaneous CAUSE write.
        csr_we = 1'b1; csr_addr = 2'd1; csr_wdata = 32'd5;
        mem_valid = 1'b1; mem_exp = 3'd2; mem_pc = ADDR_W'(8'h70);
        sb.push_back(rep_ev(3'd2));
        tick();
        csr_we = 1'b0; mem_valid = 1'b0; mem_exp = '0;
        csr_chk("t6_cause", 2'd1, 32'd2);
        tick();
        flush = 1'b1;
        sb.push_back(red_ev(ADDR_W'(4)));
        tick();
        flush = 1'b0;
        tick();

        // Writable-field masking and unmapped address.
        csr_we = 1'b1; csr_addr = 2'd2; csr_wdata = 32'hFFFF_FFFF;
        tick();
        csr_addr = 2'd1;
        tick();
        csr_addr = 2'd3;
        tick();
        csr_we = 1'b0;
        csr_chk("mask_epc", 2'd2, 32'hFFFF_FFFC);
        csr_chk("mask_cause", 2'd1, 32'd7);
        csr_chk("rd_addr3", 2'd3, 32'd0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
